// File: rtl/ctrl_pkg.sv
// Shared types and key/limit constants for the turn/aim sequencer.
package ctrl_pkg;

  typedef enum logic [1:0] {
    AIM    = 2'd0,
    LAUNCH = 2'd1,
    FLIGHT = 2'd2,
    SETTLE = 2'd3
  } turn_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic [3:0] ANGLE_MAX = 4'd8;
  localparam logic [2:0] POWER_MAX = 3'd7;

  function automatic logic is_aim_key(input logic [7:0] k);
    return (k == KEY_LEFT) || (k == KEY_RIGHT) || (k == KEY_UP) || (k == KEY_DOWN);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Keyboard front end: per-frame aim-step strobes with auto-repeat and an edge-only fire strobe.
module key_repeat
  import ctrl_pkg::*;
#(
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic       step_left,
  output logic       step_right,
  output logic       step_up,
  output logic       step_down,
  output logic       fire_edge
);

  localparam logic [7:0] RPT_LAST = 8'(REPEAT_FRAMES - 1);

  logic [7:0] prev_key;
  logic [7:0] rep_cnt;
  logic       key_new;
  logic       rep_hit;
  logic       step;

  // A new key restarts the repeat phase; a held key steps each time the counter wraps.
  assign key_new = (keycode != prev_key);
  assign rep_hit = !key_new && (rep_cnt == RPT_LAST);
  assign step    = frame_tick && is_aim_key(keycode) && (key_new || rep_hit);

  assign step_left  = step && (keycode == KEY_LEFT);
  assign step_right = step && (keycode == KEY_RIGHT);
  assign step_up    = step && (keycode == KEY_UP);
  assign step_down  = step && (keycode == KEY_DOWN);
  assign fire_edge  = frame_tick && key_new && (keycode == KEY_SPACE);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_key <= 8'h00;
      rep_cnt  <= 8'd0;
    end else if (frame_tick) begin
      prev_key <= keycode;
      if (key_new || rep_hit) rep_cnt <= 8'd0;
      else                    rep_cnt <= rep_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/launch_controller.sv
// Turn sequencer: aim editing, launch pulse with muzzle latch, flight wait, settle, then player hand-off.
module launch_controller
  import ctrl_pkg::*;
#(
  parameter int         REPEAT_FRAMES  = 8,
  parameter int         SETTLE_FRAMES  = 30,
  parameter int         FLIGHT_TIMEOUT = 600,
  parameter logic [9:0] MUZZLE_DY      = 10'd6,
  parameter logic [3:0] ANGLE_INIT     = 4'd2,
  parameter logic [2:0] POWER_INIT     = 3'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       boomed,
  input  logic [9:0] p0X,
  input  logic [9:0] p0Y,
  input  logic [9:0] p1X,
  input  logic [9:0] p1Y,
  output logic       launch,
  output logic [9:0] launchX,
  output logic [9:0] launchY,
  output logic [3:0] angle,
  output logic [2:0] power,
  output logic       player,
  output logic       turn_busy,
  output logic [1:0] dbg_state
);

  localparam logic [9:0] TIMEOUT_LAST = 10'(FLIGHT_TIMEOUT - 1);
  localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE_FRAMES - 1);

  turn_state_t state;
  logic [3:0]  angle_r [2];
  logic [2:0]  power_r [2];
  logic [9:0]  frame_cnt;
  logic        boom_low;
  logic        step_left, step_right, step_up, step_down, fire_edge;

  key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_keys (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .step_left  (step_left),
    .step_right (step_right),
    .step_up    (step_up),
    .step_down  (step_down),
    .fire_edge  (fire_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= AIM;
      player     <= 1'b0;
      launch     <= 1'b0;
      launchX    <= 10'd0;
      launchY    <= 10'd0;
      angle_r[0] <= ANGLE_INIT;
      angle_r[1] <= ANGLE_INIT;
      power_r[0] <= POWER_INIT;
      power_r[1] <= POWER_INIT;
      frame_cnt  <= 10'd0;
      boom_low   <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        AIM: begin
          // Fire wins over any aim step in the same frame.
          if (fire_edge) begin
            launch  <= 1'b1;
            state   <= LAUNCH;
            launchX <= player ? p1X : p0X;
            launchY <= (player ? p1Y : p0Y) - MUZZLE_DY;
          end else begin
            if (step_left  && angle_r[player] != 4'd0)      angle_r[player] <= angle_r[player] - 4'd1;
            if (step_right && angle_r[player] != ANGLE_MAX) angle_r[player] <= angle_r[player] + 4'd1;
            if (step_down  && power_r[player] != 3'd0)      power_r[player] <= power_r[player] - 3'd1;
            if (step_up    && power_r[player] != POWER_MAX) power_r[player] <= power_r[player] + 3'd1;
          end
        end
        LAUNCH: begin
          launch    <= 1'b0;
          state     <= FLIGHT;
          frame_cnt <= 10'd0;
          boom_low  <= 1'b0;
        end
        FLIGHT: begin
          // Only a 0 -> 1 transition of boomed ends the flight early.
          if ((boom_low && boomed) || frame_cnt == TIMEOUT_LAST) begin
            state     <= SETTLE;
            frame_cnt <= 10'd0;
          end else begin
            frame_cnt <= frame_cnt + 10'd1;
            if (!boomed) boom_low <= 1'b1;
          end
        end
        SETTLE: begin
          if (frame_cnt == SETTLE_LAST) begin
            player    <= ~player;
            state     <= AIM;
            frame_cnt <= 10'd0;
          end else begin
            frame_cnt <= frame_cnt + 10'd1;
          end
        end
        default: state <= AIM;
      endcase
    end
  end

  assign angle     = angle_r[player];
  assign power     = power_r[player];
  assign turn_busy = (state != AIM);
  assign dbg_state = state;

endmodule

// File: tb/tb_launch_controller.sv
// Self-checking bench for launch_controller: table vectors plus hand sequences, checked through an expected queue.
module tb_launch_controller;

  localparam int FP = 4;  // clocks per frame
  localparam logic [1:0] S_AIM = 2'd0, S_LAUNCH = 2'd1, S_FLIGHT = 2'd2, S_SETTLE = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       boomed = 1'b1;
  logic [9:0] p0X = 10'd100, p0Y = 10'd300, p1X = 10'd700, p1Y = 10'd5;
  logic       launch;
  logic [9:0] launchX, launchY;
  logic [3:0] angle;
  logic [2:0] power;
  logic       player, turn_busy;
  logic [1:0] dbg_state;

  launch_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode), .boomed(boomed),
    .p0X(p0X), .p0Y(p0Y), .p1X(p1X), .p1Y(p1Y),
    .launch(launch), .launchX(launchX), .launchY(launchY), .angle(angle), .power(power),
    .player(player), .turn_busy(turn_busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic       bm;
    logic       l;
    logic [9:0] lx, ly;
    logic [3:0] a;
    logic [2:0] p;
    logic       pl, busy;
    logic [1:0] st;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] pk(input logic l, input logic [9:0] lx, input logic [9:0] ly,
                                     input logic [3:0] a, input logic [2:0] p, input logic pl,
                                     input logic busy, input logic [1:0] st);
    return {l, lx, ly, a, p, pl, busy, st};
  endfunction

  task automatic check_out();
    logic [31:0] e, obs;
    string nm;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got=empty queue want=entry");
      return;
    end
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    obs = {launch, launchX, launchY, angle, power, player, turn_busy, dbg_state};
    if (obs !== e) begin
      bad++;
      $display("FAIL %s: got l=%0b x=%0d y=%0d a=%0d p=%0d pl=%0b busy=%0b st=%0d want l=%0b x=%0d y=%0d a=%0d p=%0d pl=%0b busy=%0b st=%0d",
               nm, obs[31], obs[30:21], obs[20:11], obs[10:7], obs[6:4], obs[3], obs[2], obs[1:0],
               e[31], e[30:21], e[20:11], e[10:7], e[6:4], e[3], e[2], e[1:0]);
    end
  endtask

  // One frame: drive inputs, pulse frame_tick for one clock, check at the following negedge.
  task automatic run_frame(input logic [7:0] k, input logic bm, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    keycode    = k;
    boomed     = bm;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_out();
    repeat (FP - 2) @(negedge clk);
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk);
    reset      = 1'b1;
    frame_tick = 1'b0;
    keycode    = 8'h00;
    exp_q.push_back(pk(1'b0, 10'd0, 10'd0, 4'd2, 3'd3, 1'b0, 1'b0, S_AIM));
    name_q.push_back(nm);
    @(negedge clk);
    check_out();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h00, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd0, 1'b0, 1'b0, S_AIM};
    tbl[1]  = '{8'h52, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd1, 1'b0, 1'b0, S_AIM};
    tbl[2]  = '{8'h00, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd1, 1'b0, 1'b0, S_AIM};
    tbl[3]  = '{8'h52, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd2, 1'b0, 1'b0, S_AIM};
    tbl[4]  = '{8'h52, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd2, 1'b0, 1'b0, S_AIM};
    tbl[5]  = '{8'h50, 1'b1, 1'b0, 10'd0,   10'd0,   4'd7, 3'd2, 1'b0, 1'b0, S_AIM};
    tbl[6]  = '{8'h00, 1'b1, 1'b0, 10'd0,   10'd0,   4'd7, 3'd2, 1'b0, 1'b0, S_AIM};
    tbl[7]  = '{8'h4F, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd2, 1'b0, 1'b0, S_AIM};
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd2, 1'b0, 1'b0, S_AIM};
    tbl[9]  = '{8'h51, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd1, 1'b0, 1'b0, S_AIM};
    tbl[10] = '{8'h00, 1'b1, 1'b0, 10'd0,   10'd0,   4'd8, 3'd1, 1'b0, 1'b0, S_AIM};
    tbl[11] = '{8'h2C, 1'b1, 1'b1, 10'd100, 10'd294, 4'd8, 3'd1, 1'b0, 1'b1, S_LAUNCH};
    tbl[12] = '{8'h2C, 1'b1, 1'b0, 10'd100, 10'd294, 4'd8, 3'd1, 1'b0, 1'b1, S_FLIGHT};

    // Reset state, then confirm nothing moves without frame_tick.
    repeat (3) @(negedge clk);
    pulse_reset("reset_state");
    keycode = 8'h4F;
    exp_q.push_back(pk(1'b0, 10'd0, 10'd0, 4'd2, 3'd3, 1'b0, 1'b0, S_AIM));
    name_q.push_back("no_tick_hold");
    repeat (3) @(negedge clk);
    check_out();
    keycode = 8'h00;

    // RIGHT held 40 frames: steps at frames 0,8,16,24,32.
    for (int i = 0; i < 40; i++)
      run_frame(8'h4F, 1'b1, pk(1'b0, 10'd0, 10'd0, 4'(3 + i / 8), 3'd3, 1'b0, 1'b0, S_AIM), "repeat_right");
    run_frame(8'h00, 1'b1, pk(1'b0, 10'd0, 10'd0, 4'd7, 3'd3, 1'b0, 1'b0, S_AIM), "release_right");

    // Angle saturates at 8.
    for (int i = 0; i < 20; i++)
      run_frame(8'h4F, 1'b1, pk(1'b0, 10'd0, 10'd0, 4'd8, 3'd3, 1'b0, 1'b0, S_AIM), "sat_right");
    run_frame(8'h00, 1'b1, pk(1'b0, 10'd0, 10'd0, 4'd8, 3'd3, 1'b0, 1'b0, S_AIM), "release_sat");

    // DOWN held 100 frames from power 3: 2,1,0 then holds at 0.
    for (int i = 0; i < 100; i++) begin
      int steps;
      steps = 1 + i / 8;
      run_frame(8'h51, 1'b1, pk(1'b0, 10'd0, 10'd0, 4'd8, (steps >= 3) ? 3'd0 : 3'(3 - steps),
                                1'b0, 1'b0, S_AIM), "sat_down");
    end

    // Short edits, then fire from p0 = (100,300).
    for (int i = 0; i < 13; i++)
      run_frame(tbl[i].key, tbl[i].bm,
                pk(tbl[i].l, tbl[i].lx, tbl[i].ly, tbl[i].a, tbl[i].p, tbl[i].pl, tbl[i].busy, tbl[i].st),
                $sformatf("table_%0d", i));

    // SPACE held and boomed stuck high: single launch, flight continues.
    for (int i = 0; i < 48; i++)
      run_frame(8'h2C, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd8, 3'd1, 1'b0, 1'b1, S_FLIGHT), "hold_space_flight");
    run_frame(8'h2C, 1'b0, pk(1'b0, 10'd100, 10'd294, 4'd8, 3'd1, 1'b0, 1'b1, S_FLIGHT), "boom_low");
    run_frame(8'h2C, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd8, 3'd1, 1'b0, 1'b1, S_SETTLE), "boom_rise");

    // Settle 30 frames with SPACE still held; hand-off must not fire.
    for (int i = 1; i <= 30; i++)
      run_frame(8'h2C, 1'b1, (i < 30) ? pk(1'b0, 10'd100, 10'd294, 4'd8, 3'd1, 1'b0, 1'b1, S_SETTLE)
                                      : pk(1'b0, 10'd100, 10'd294, 4'd2, 3'd3, 1'b1, 1'b0, S_AIM), "settle1");
    run_frame(8'h2C, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd2, 3'd3, 1'b1, 1'b0, S_AIM), "no_fire_carry");
    run_frame(8'h00, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd2, 3'd3, 1'b1, 1'b0, S_AIM), "release_space");
    run_frame(8'h4F, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd3, 3'd3, 1'b1, 1'b0, S_AIM), "p1_right");
    run_frame(8'h00, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd3, 3'd3, 1'b1, 1'b0, S_AIM), "p1_release");

    // Player 1 fires from (700,5): launchY wraps to 1023; boomed never drops -> timeout.
    run_frame(8'h2C, 1'b1, pk(1'b1, 10'd700, 10'd1023, 4'd3, 3'd3, 1'b1, 1'b1, S_LAUNCH), "p1_fire");
    run_frame(8'h00, 1'b1, pk(1'b0, 10'd700, 10'd1023, 4'd3, 3'd3, 1'b1, 1'b1, S_FLIGHT), "p1_flight");
    for (int k = 1; k <= 600; k++)
      run_frame(8'h00, 1'b1, pk(1'b0, 10'd700, 10'd1023, 4'd3, 3'd3, 1'b1, 1'b1,
                                (k < 600) ? S_FLIGHT : S_SETTLE), "timeout");
    for (int k = 1; k <= 30; k++)
      run_frame(8'h00, 1'b1, (k < 30) ? pk(1'b0, 10'd700, 10'd1023, 4'd3, 3'd3, 1'b1, 1'b1, S_SETTLE)
                                      : pk(1'b0, 10'd700, 10'd1023, 4'd8, 3'd1, 1'b0, 1'b0, S_AIM), "settle2");

    // Reset mid-LAUNCH.
    run_frame(8'h2C, 1'b1, pk(1'b1, 10'd100, 10'd294, 4'd8, 3'd1, 1'b0, 1'b1, S_LAUNCH), "fire3");
    pulse_reset("rst_mid_launch");

    // Reset mid-SETTLE after a player-0 edit.
    run_frame(8'h4F, 1'b1, pk(1'b0, 10'd0, 10'd0, 4'd3, 3'd3, 1'b0, 1'b0, S_AIM), "p0_edit");
    run_frame(8'h2C, 1'b1, pk(1'b1, 10'd100, 10'd294, 4'd3, 3'd3, 1'b0, 1'b1, S_LAUNCH), "fire4");
    run_frame(8'h00, 1'b0, pk(1'b0, 10'd100, 10'd294, 4'd3, 3'd3, 1'b0, 1'b1, S_FLIGHT), "flight4");
    run_frame(8'h00, 1'b0, pk(1'b0, 10'd100, 10'd294, 4'd3, 3'd3, 1'b0, 1'b1, S_FLIGHT), "boom_low4");
    run_frame(8'h00, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd3, 3'd3, 1'b0, 1'b1, S_SETTLE), "boom_rise4");
    run_frame(8'h00, 1'b1, pk(1'b0, 10'd100, 10'd294, 4'd3, 3'd3, 1'b0, 1'b1, S_SETTLE), "settle4");
    pulse_reset("rst_mid_settle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
